// File: rtl/motor_speed_frame_rx.sv
// Framed multi-motor speed receiver: SYNC, payload, checksum.
// Outputs update atomically on a verified frame; timeout and stale detection.
module motor_speed_frame_rx #(
   parameter int unsigned NUM_MOTORS  = 4,
   parameter int unsigned SPEED_W     = 8,
   parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned STALE_CYC   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    serial,
   input  logic                          received,
   output logic [NUM_MOTORS*SPEED_W-1:0] motor_speed,
   output logic                          frame_valid,
   output logic                          frame_err,
   output logic                          timeout_err,
   output logic                          stale
);

   localparam int unsigned BPM = SPEED_W / 8;
   localparam int unsigned P   = NUM_MOTORS * BPM;
   localparam int unsigned PW  = P * 8;
   localparam int unsigned CW  = $clog2(P + 1);
   localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sum_q, sum_d;
   logic [PW-1:0] shadow_q, shadow_d, shifted;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [PW-1:0] speed_q, speed_d, frame_speed;
   logic          fv_q, fe_q, to_q;
   logic          ok_ev, err_ev, tmo_ev, expire, stale_hit;

   // Payload arrives MSB-first per motor, motor 0 first, so a left shift
   // leaves motor 0 in the top slice of the shadow register.
   if (PW > 8) begin : g_shift
      assign shifted = {shadow_q[PW-9:0], serial};
   end else begin : g_shift1
      assign shifted = serial;
   end

   for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_map
      assign frame_speed[k*SPEED_W +: SPEED_W] =
         shadow_q[(NUM_MOTORS-1-k)*SPEED_W +: SPEED_W];
   end

   assign expire = (state_q != HUNT) && !received
                   && (tmr_q == TW'(TIMEOUT_CYC - 1));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   // FSM next state; a byte on the expiry cycle wins over the timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT:    if (received && serial == SYNC_BYTE) state_d = PAYLOAD;
         PAYLOAD: if (received) begin
                     if (cnt_q == CW'(P - 1)) state_d = CHECK;
                  end else if (expire) state_d = HUNT;
         CHECK:   if (received || expire) state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   // FSM outputs: frame outcome events, mutually exclusive by construction
   always_comb begin
      ok_ev  = 1'b0;
      err_ev = 1'b0;
      tmo_ev = expire;
      if (state_q == CHECK && received) begin
         ok_ev  = (serial == sum_q);
         err_ev = (serial != sum_q);
      end
   end

   // Datapath next state: counter, checksum, shadow, inter-byte timer
   always_comb begin
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      shadow_d = shadow_q;
      tmr_d    = (received || state_q == HUNT || expire)
                 ? '0 : tmr_q + TW'(1);
      if (received) begin
         unique case (state_q)
            HUNT: if (serial == SYNC_BYTE) begin
                     cnt_d    = '0;
                     sum_d    = '0;
                     shadow_d = '0;
                  end
            PAYLOAD: begin
                     shadow_d = shifted;
                     sum_d    = sum_q + serial;
                     cnt_d    = cnt_q + CW'(1);
                  end
            default: ;
         endcase
      end
   end

   // Motor outputs: load on good frame, zero when the link goes stale
   always_comb begin
      speed_d = speed_q;
      if (ok_ev)          speed_d = frame_speed;
      else if (stale_hit) speed_d = '0;
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         sum_q    <= '0;
         shadow_q <= '0;
         tmr_q    <= '0;
         speed_q  <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         shadow_q <= shadow_d;
         tmr_q    <= tmr_d;
         speed_q  <= speed_d;
         fv_q     <= ok_ev;
         fe_q     <= err_ev;
         to_q     <= tmo_ev;
      end
   end

   if (STALE_CYC > 0) begin : g_stale
      localparam int unsigned SCW = $clog2(STALE_CYC + 1);
      logic [SCW-1:0] scnt_q, scnt_d;
      logic           st_q;

      // Stale counter: cleared by a good frame, saturates at the limit
      always_comb begin
         if (ok_ev)                            scnt_d = '0;
         else if (scnt_q != SCW'(STALE_CYC))   scnt_d = scnt_q + SCW'(1);
         else                                  scnt_d = scnt_q;
      end

      assign stale_hit = !ok_ev && (scnt_d == SCW'(STALE_CYC));

      // Stale counter and level register
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            scnt_q <= '0;
            st_q   <= 1'b0;
         end else begin
            scnt_q <= scnt_d;
            st_q   <= stale_hit;
         end
      end

      assign stale = st_q;
   end else begin : g_no_stale
      assign stale_hit = 1'b0;
      assign stale     = 1'b0;
   end

   assign motor_speed = speed_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_motor_speed_frame_rx.sv
// Randomised bench for motor_speed_frame_rx against a queue-based
// frame model; every cycle's outputs are compared.
module tb_motor_speed_frame_rx;

   localparam int NM  = 3;
   localparam int SW  = 16;
   localparam int TO  = 24;
   localparam int ST  = 300;
   localparam int BPM = SW / 8;
   localparam int P   = NM * BPM;
   localparam logic [7:0] SYNC = 8'hAA;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      serial;
   logic            received;
   logic [NM*SW-1:0] motor_speed;
   logic            frame_valid, frame_err, timeout_err, stale;

   int n_chk  = 0;
   int n_pass = 0;

   bit              m_in;
   logic [7:0]      m_q[$];
   int              m_idle, m_since;
   logic [NM*SW-1:0] e_speed;
   bit              e_fv, e_fe, e_to, e_st;

   always #5 clk = ~clk;

   motor_speed_frame_rx #(
      .NUM_MOTORS(NM), .SPEED_W(SW), .SYNC_BYTE(SYNC),
      .TIMEOUT_CYC(TO), .STALE_CYC(ST)
   ) dut (
      .clk(clk), .rst(rst), .serial(serial), .received(received),
      .motor_speed(motor_speed), .frame_valid(frame_valid),
      .frame_err(frame_err), .timeout_err(timeout_err), .stale(stale)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_in = 0; m_q.delete(); m_idle = 0; m_since = 0;
      e_speed = '0; e_fv = 0; e_fe = 0; e_to = 0; e_st = 0;
   endtask

   // Frame-level reference: collect bytes, judge the frame on its checksum
   task automatic model_step(input bit rcv, input logic [7:0] b);
      int s;
      logic [SW-1:0] v;
      e_fv = 0; e_fe = 0; e_to = 0;
      if (rcv) begin
         m_idle = 0;
         if (!m_in) begin
            if (b == SYNC) begin m_in = 1; m_q.delete(); end
         end else if (m_q.size() < P) begin
            m_q.push_back(b);
         end else begin
            s = 0;
            foreach (m_q[i]) s += int'(m_q[i]);
            if (int'(b) == s % 256) begin
               for (int k = 0; k < NM; k++) begin
                  v = '0;
                  for (int j = 0; j < BPM; j++)
                     v = (v << 8) | SW'(m_q[k*BPM + j]);
                  e_speed[k*SW +: SW] = v;
               end
               e_fv = 1;
            end else e_fe = 1;
            m_in = 0;
         end
      end else if (m_in) begin
         if (m_idle == TO - 1) begin e_to = 1; m_in = 0; m_idle = 0; end
         else m_idle++;
      end
      if (e_fv) begin
         m_since = 0; e_st = 0;
      end else if (m_since < ST) begin
         m_since++;
         if (m_since == ST) begin e_st = 1; e_speed = '0; end
      end
   endtask

   task automatic compare_all();
      chk("speed",  64'(motor_speed), 64'(e_speed));
      chk("fvalid", 64'(frame_valid), 64'(e_fv));
      chk("ferr",   64'(frame_err),   64'(e_fe));
      chk("tmo",    64'(timeout_err), 64'(e_to));
      chk("stale",  64'(stale),       64'(e_st));
      chk("excl", 64'(int'(frame_valid) + int'(frame_err)
                      + int'(timeout_err) > 1), 64'(0));
   endtask

   task automatic tick(input bit rcv, input logic [7:0] b);
      received = rcv;
      serial   = b;
      model_step(rcv, b);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'($urandom));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      idle(gap);
      tick(1'b1, b);
   endtask

   function automatic int rgap();
      int r;
      r = $urandom_range(0, 19);
      if (r < 14) return $urandom_range(0, 2);
      if (r < 17) return TO - 1;
      if (r < 19) return TO - 2;
      return TO;
   endfunction

   // kind: 0 good, 1 corrupted checksum, 2 truncated
   task automatic send_frame(input int kind);
      logic [7:0] pl[$];
      logic [7:0] b, c;
      int s, n;
      s = 0;
      for (int i = 0; i < P; i++) begin
         b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
         pl.push_back(b);
         s += int'(b);
      end
      send_byte(SYNC, rgap());
      if (kind == 2) begin
         n = $urandom_range(0, P);
         for (int i = 0; i < n; i++) send_byte(pl[i], rgap());
         idle(TO + $urandom_range(0, 3));
      end else begin
         foreach (pl[i]) send_byte(pl[i], rgap());
         c = 8'(s % 256);
         if (kind == 1) c = c ^ 8'(1 << $urandom_range(0, 7));
         send_byte(c, rgap());
      end
   endtask

   initial begin
      rst = 1'b1; received = 1'b0; serial = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      send_byte(SYNC, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h78, 0); send_byte(8'h9A, 0); send_byte(8'hBC, 0);
      send_byte(8'h6A, 0);
      chk("d1_speed", 64'(motor_speed), 64'h9ABC_5678_1234);
      chk("d1_fv", 64'(frame_valid), 64'd1);

      send_byte(SYNC, 1);
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
      send_byte(8'h00, 0);
      chk("d2_fe", 64'(frame_err), 64'd1);
      chk("d2_keep", 64'(motor_speed), 64'h9ABC_5678_1234);

      send_byte(SYNC, 2); send_byte(8'h10, 0); send_byte(8'h20, 0);
      idle(TO);
      chk("d3_to", 64'(timeout_err), 64'd1);
      send_byte(SYNC, 0);
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
      send_byte(8'h15, 0);
      chk("d3_speed", 64'(motor_speed), 64'h0506_0304_0102);

      for (int i = 0; i < 5; i++) send_byte(8'h55 + 8'(i), 0);
      send_byte(SYNC, 0); send_byte(SYNC, 0);
      for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
      send_byte(SYNC, 0);
      chk("d4_speed", 64'(motor_speed), 64'h0000_0000_AA00);

      for (int f = 0; f < 150; f++) begin
         int r;
         r = $urandom_range(0, 9);
         send_frame(r < 6 ? 0 : (r < 8 ? 1 : 2));
         if ($urandom_range(0, 3) == 0)
            send_byte(8'($urandom), $urandom_range(0, 4));
      end

      send_frame(0);
      idle(ST + 5);
      chk("d6_stale", 64'(stale), 64'd1);
      chk("d6_zero", 64'(motor_speed), 64'd0);
      send_frame(0);

      send_byte(SYNC, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(8'h33 + 8'(i), 0);
      send_frame(0);
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
